// File: rtl/ma_stage_lsu_if.sv
// Memory-access stage bus: execute request, data-memory port and writeback result.
// master = the surrounding pipeline/memory, slave = the stage itself.
interface ma_stage_lsu_if #(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      ex_valid;
  logic                      ex_ready;
  logic [31:0]               ex_alu_result;
  logic [31:0]               ex_store_data;
  logic                      ex_is_ld;
  logic                      ex_is_st;
  logic [1:0]                ex_size;
  logic                      ex_unsigned;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_wb_en;

  logic [MEM_ADDR_WIDTH-1:0] dmem_waddr;
  logic [31:0]               dmem_wdata;
  logic [3:0]                dmem_wbe;
  logic                      dmem_wen;
  logic [MEM_ADDR_WIDTH-1:0] dmem_raddr;
  logic                      dmem_ren;
  logic [31:0]               dmem_rdata;

  logic                      ma_valid;
  logic                      ma_ready;
  logic [31:0]               ma_result;
  logic [REG_ADDR_WIDTH-1:0] ma_rd;
  logic                      ma_wb_en;
  logic                      ma_misalign;

  modport master (
    output ex_valid, ex_alu_result, ex_store_data, ex_is_ld, ex_is_st,
           ex_size, ex_unsigned, ex_rd, ex_wb_en, ma_ready, dmem_rdata,
    input  ex_ready, dmem_waddr, dmem_wdata, dmem_wbe, dmem_wen,
           dmem_raddr, dmem_ren, ma_valid, ma_result, ma_rd, ma_wb_en,
           ma_misalign
  );

  modport slave (
    input  ex_valid, ex_alu_result, ex_store_data, ex_is_ld, ex_is_st,
           ex_size, ex_unsigned, ex_rd, ex_wb_en, ma_ready, dmem_rdata,
    output ex_ready, dmem_waddr, dmem_wdata, dmem_wbe, dmem_wen,
           dmem_raddr, dmem_ren, ma_valid, ma_result, ma_rd, ma_wb_en,
           ma_misalign
  );
endinterface

// File: rtl/ma_stage_lsu.sv
// Memory-access stage: sized/byte-enabled stores, sign/zero-extended loads with a
// fixed read latency, misalignment flagging and a one-entry output register.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | can accept when the output register is free or draining
//   RD_WAIT | aligned load issued; counting down until dmem_rdata is valid
module ma_stage_lsu #(
  parameter int MEM_ADDR_WIDTH = 12,
  parameter int RD_LATENCY     = 1,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic           clk,
  input logic           rst,
  ma_stage_lsu_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  state_t                    state;
  logic [1:0]                lat_cnt;
  logic [1:0]                ld_off;
  logic [1:0]                ld_size;
  logic                      ld_unsigned;
  logic [REG_ADDR_WIDTH-1:0] ld_rd;
  logic                      ld_wb_en;

  logic                      ma_valid_q;
  logic [31:0]               ma_result_q;
  logic [REG_ADDR_WIDTH-1:0] ma_rd_q;
  logic                      ma_wb_en_q;
  logic                      ma_misalign_q;

  logic [1:0]  off;
  logic        is_mem;
  logic        misalign;
  logic        accept;
  logic        do_ld;
  logic        do_st;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] rd_shift;
  logic [31:0] ld_data;

  assign off      = bus.ex_alu_result[1:0];
  assign is_mem   = bus.ex_is_ld | bus.ex_is_st;
  assign misalign = is_mem & (((bus.ex_size == 2'b01) & off[0]) |
                              (bus.ex_size[1] & (off != 2'b00)));

  // rst gates ex_ready so nothing is accepted and no strobe leaks during reset
  assign bus.ex_ready = ~rst & (state == IDLE) & (~ma_valid_q | bus.ma_ready);
  assign accept       = bus.ex_valid & bus.ex_ready;
  assign do_ld        = accept & bus.ex_is_ld & ~misalign;
  assign do_st        = accept & bus.ex_is_st & ~misalign;

  // Place store data on every lane it could land in and enable only the addressed ones
  always_comb begin
    st_be   = 4'b1111;
    st_data = bus.ex_store_data;
    case (bus.ex_size)
      2'b00: begin
        st_be   = 4'b0001 << off;
        st_data = {4{bus.ex_store_data[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << {off[1], 1'b0};
        st_data = {2{bus.ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign bus.dmem_wen   = do_st;
  assign bus.dmem_waddr = do_st ? bus.ex_alu_result[MEM_ADDR_WIDTH+1:2] : '0;
  assign bus.dmem_wbe   = do_st ? st_be : 4'b0000;
  assign bus.dmem_wdata = do_st ? st_data : 32'h0;
  assign bus.dmem_ren   = do_ld;
  assign bus.dmem_raddr = do_ld ? bus.ex_alu_result[MEM_ADDR_WIDTH+1:2] : '0;

  // Align the returned word using the offset/size captured when the load was accepted
  always_comb begin
    rd_shift = bus.dmem_rdata >> {ld_off, 3'b000};
    case (ld_size)
      2'b00:   ld_data = {{24{~ld_unsigned & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_data = {{16{~ld_unsigned & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_data = rd_shift;
    endcase
  end

  // FSM, load context and output register; a drain and a new fill may share one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= 2'd0;
      ld_off        <= 2'd0;
      ld_size       <= 2'd0;
      ld_unsigned   <= 1'b0;
      ld_rd         <= '0;
      ld_wb_en      <= 1'b0;
      ma_valid_q    <= 1'b0;
      ma_result_q   <= 32'h0;
      ma_rd_q       <= '0;
      ma_wb_en_q    <= 1'b0;
      ma_misalign_q <= 1'b0;
    end else begin
      if (ma_valid_q && bus.ma_ready) ma_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (do_ld) begin
            state       <= RD_WAIT;
            lat_cnt     <= 2'(RD_LATENCY - 1);
            ld_off      <= off;
            ld_size     <= bus.ex_size;
            ld_unsigned <= bus.ex_unsigned;
            ld_rd       <= bus.ex_rd;
            ld_wb_en    <= bus.ex_wb_en;
          end else if (accept) begin
            ma_valid_q    <= 1'b1;
            ma_result_q   <= bus.ex_alu_result;
            ma_rd_q       <= bus.ex_rd;
            ma_wb_en_q    <= bus.ex_wb_en & ~bus.ex_is_st & ~misalign;
            ma_misalign_q <= misalign;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 2'd0) begin
            state         <= IDLE;
            ma_valid_q    <= 1'b1;
            ma_result_q   <= ld_data;
            ma_rd_q       <= ld_rd;
            ma_wb_en_q    <= ld_wb_en;
            ma_misalign_q <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ma_valid    = ma_valid_q;
  assign bus.ma_result   = ma_result_q;
  assign bus.ma_rd       = ma_rd_q;
  assign bus.ma_wb_en    = ma_wb_en_q;
  assign bus.ma_misalign = ma_misalign_q;
endmodule
